// File: rtl/led_matrix_scanner_if.sv
// Display bundle between the sequencer core and the LED matrix scanner.
// The core drives enable/pattern/playhead and the scanner returns the matrix lines.
interface led_matrix_scanner_if #(
    parameter int NUM_BEATS = 16
);
    logic                   enable;
    logic [NUM_BEATS*4-1:0] beats;
    logic [3:0]             beat_count;
    logic [3:0]             row_outputs;
    logic [3:0]             col_outputs;
    logic                   frame_done;

    modport master (
        output enable,
        output beats,
        output beat_count,
        input  row_outputs,
        input  col_outputs,
        input  frame_done
    );

    modport slave (
        input  enable,
        input  beats,
        input  beat_count,
        output row_outputs,
        output col_outputs,
        output frame_done
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 4x4 LED matrix driver with a blanking gap per row
// slot and a blinking playhead step.
module led_matrix_scanner #(
    parameter int ROW_TICKS   = 3000,
    parameter int BLANK_TICKS = 60,
    parameter int BLINK_TICKS = 3_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    led_matrix_scanner_if.slave bus
);
    localparam int CW = $clog2(ROW_TICKS);
    localparam int BW = $clog2(BLINK_TICKS);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [CW-1:0] ROW_LAST   = CW'(ROW_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    row_idx, row_n;
    logic [3:0]    vec, vec_n;
    logic [3:0]    shown;
    logic [3:0]    rows, rows_n;
    logic [3:0]    cols, cols_n;
    logic          done, done_n;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Column vector for the current row: lit steps, playhead inverted.
    always_comb begin
        logic [3:0] step;
        step  = 4'd0;
        shown = 4'd0;
        for (int c = 0; c < 4; c++) begin
            step     = {row_idx, 2'(c)};
            shown[c] = (bus.beats[{step, 2'b00} +: 4] != 4'd0)
                     ^ (blink_phase && (step == bus.beat_count));
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        row_n   = row_idx;
        vec_n   = vec;
        rows_n  = 4'b0000;
        cols_n  = 4'b1111;
        done_n  = 1'b0;
        if (!bus.enable) begin
            state_n = BLANK;
            cnt_n   = '0;
            row_n   = 2'd0;
        end else begin
            unique case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = DRIVE;
                        vec_n   = shown;
                        rows_n  = 4'b0001 << row_idx;
                        cols_n  = ~shown;
                    end
                end
                DRIVE: begin
                    if (cnt == ROW_LAST) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        row_n   = row_idx + 2'd1;
                        done_n  = (row_idx == 2'd3);
                    end else begin
                        rows_n = 4'b0001 << row_idx;
                        cols_n = ~vec;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BLANK;
            cnt     <= '0;
            row_idx <= 2'd0;
            vec     <= 4'd0;
            rows    <= 4'b0000;
            cols    <= 4'b1111;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            row_idx <= row_n;
            vec     <= vec_n;
            rows    <= rows_n;
            cols    <= cols_n;
            done    <= done_n;
        end
    end

    assign bus.row_outputs = rows;
    assign bus.col_outputs = cols;
    assign bus.frame_done  = done;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: directed scenarios plus random pattern
// traffic against a time-based reference model of the scan.
module tb_led_matrix_scanner;
    localparam int ROW   = 8;
    localparam int BLANK = 2;
    localparam int BLINK = 20;
    localparam int FRAME = 4 * ROW;

    logic clk;
    logic rst_n;

    led_matrix_scanner_if #(.NUM_BEATS(16)) ifc ();

    led_matrix_scanner #(
        .ROW_TICKS  (ROW),
        .BLANK_TICKS(BLANK),
        .BLINK_TICKS(BLINK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    logic [3:0] pat[16];

    int         m_t;
    int         m_bl;
    logic [3:0] m_vec;
    logic [3:0] m_rows;
    logic [3:0] m_cols;
    logic       m_done;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic apply_pat();
        for (int s = 0; s < 16; s++) ifc.beats[s*4 +: 4] = pat[s];
    endtask

    function automatic logic [3:0] shown_ref(input int r, input logic ph);
        logic [3:0] v;
        v = 4'd0;
        for (int c = 0; c < 4; c++) begin
            int s;
            s    = r * 4 + c;
            v[c] = (pat[s] != 4'd0) ^ (ph && (s == int'(ifc.beat_count)));
        end
        return v;
    endfunction

    task automatic model_reset();
        m_t    = 0;
        m_bl   = 0;
        m_vec  = 4'd0;
        m_rows = 4'b0000;
        m_cols = 4'b1111;
        m_done = 1'b0;
    endtask

    // Scan position is pure arithmetic on cycles since the scan restarted.
    task automatic model_step();
        int   p;
        logic ph;
        if (!rst_n) return;
        ph = ((m_bl / BLINK) % 2) == 1;
        m_bl++;
        if (!ifc.enable) begin
            m_t    = 0;
            m_rows = 4'b0000;
            m_cols = 4'b1111;
            m_done = 1'b0;
            return;
        end
        m_t++;
        p      = m_t % FRAME;
        m_done = (p == 0);
        if (p % ROW == BLANK) m_vec = shown_ref(p / ROW, ph);
        if (p % ROW < BLANK) begin
            m_rows = 4'b0000;
            m_cols = 4'b1111;
        end else begin
            m_rows = 4'b0001 << (p / ROW);
            m_cols = ~m_vec;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("row_outputs", 32'(ifc.row_outputs), 32'(m_rows));
        chk("col_outputs", 32'(ifc.col_outputs), 32'(m_cols));
        chk("frame_done", 32'(ifc.frame_done), 32'(m_done));
    endtask

    task automatic tick_to(input int pos);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (m_t % FRAME == pos) return;
            tick();
        end
        chk("tick_to_bound", 32'(m_t % FRAME), 32'(pos));
    endtask

    initial begin
        logic [3:0] exp_cols[4];
        int         on_cnt;
        int         off_cnt;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        ifc.enable     = 1'b1;
        ifc.beat_count = 4'd8;
        for (int s = 0; s < 16; s++) pat[s] = 4'd0;
        pat[0]  = 4'h3;
        pat[5]  = 4'h3;
        pat[10] = 4'h3;
        pat[15] = 4'h3;
        apply_pat();
        model_reset();

        repeat (3) @(negedge clk);
        chk("reset_rows", 32'(ifc.row_outputs), 32'h0);
        chk("reset_cols", 32'(ifc.col_outputs), 32'hf);
        chk("reset_done", 32'(ifc.frame_done), 32'h0);
        rst_n = 1'b1;

        // Diagonal pattern and frame pulse cadence.
        exp_cols[0] = 4'b1110;
        exp_cols[1] = 4'b1101;
        exp_cols[2] = 4'b1011;
        exp_cols[3] = 4'b0111;
        for (int i = 1; i <= 3 * FRAME; i++) begin
            tick();
            if (i <= FRAME && i % ROW == BLANK) begin
                chk("diag_rows", 32'(ifc.row_outputs),
                    32'(4'b0001 << (i / ROW)));
                chk("diag_cols", 32'(ifc.col_outputs),
                    32'(exp_cols[i/ROW]));
            end
            chk("frame_cadence", 32'(ifc.frame_done), 32'(i % FRAME == 0));
        end

        // Asynchronous reset in the middle of row 2.
        tick_to(20);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rows", 32'(ifc.row_outputs), 32'h0);
        chk("async_rst_cols", 32'(ifc.col_outputs), 32'hf);
        chk("async_rst_done", 32'(ifc.frame_done), 32'h0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_blank", 32'(ifc.row_outputs), 32'h0);
        tick();
        chk("post_rst_row0", 32'(ifc.row_outputs), 32'h1);

        // Blinking playhead on an empty pattern, then on a lit step.
        for (int s = 0; s < 16; s++) pat[s] = 4'd0;
        apply_pat();
        ifc.beat_count = 4'd6;
        for (int pass = 0; pass < 2; pass++) begin
            on_cnt  = 0;
            off_cnt = 0;
            for (int i = 0; i < 6 * FRAME; i++) begin
                tick();
                if (m_t % FRAME >= ROW + BLANK && m_t % FRAME < 2 * ROW) begin
                    if (ifc.col_outputs == 4'b1011) on_cnt++;
                    if (ifc.col_outputs == 4'b1111) off_cnt++;
                end
            end
            chk("blink_on_seen", 32'(on_cnt > 0), 32'h1);
            chk("blink_off_seen", 32'(off_cnt > 0), 32'h1);
            pat[6] = 4'h1;
            apply_pat();
        end

        // Pattern change mid-row must not tear the driven row.
        for (int s = 0; s < 16; s++) pat[s] = 4'd0;
        apply_pat();
        ifc.beat_count = 4'd15;
        tick_to(ROW + 5);
        pat[4] = 4'h7;
        apply_pat();
        tick();
        chk("snapshot_hold0", 32'(ifc.col_outputs), 32'hf);
        tick();
        chk("snapshot_hold1", 32'(ifc.col_outputs), 32'hf);
        tick_to(ROW + BLANK);
        chk("snapshot_next", 32'(ifc.col_outputs), 32'he);

        // Enable drop during row 2, then restart.
        tick_to(2 * ROW + 4);
        ifc.enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("en_low_rows", 32'(ifc.row_outputs), 32'h0);
            chk("en_low_cols", 32'(ifc.col_outputs), 32'hf);
        end
        ifc.enable = 1'b1;
        tick();
        chk("en_rise_blank", 32'(ifc.row_outputs), 32'h0);
        tick();
        chk("en_rise_row0", 32'(ifc.row_outputs), 32'h1);
        for (int i = 3; i <= FRAME; i++) begin
            tick();
            chk("en_frame_done", 32'(ifc.frame_done), 32'(i == FRAME));
        end

        // Random pattern, playhead and enable traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 6 == 0) begin
                pat[$urandom % 16] = ($urandom % 2 == 0) ? 4'd0 :
                                     4'($urandom % 16);
                apply_pat();
            end
            if ($urandom % 10 == 0) ifc.beat_count = 4'($urandom % 16);
            if ($urandom % 60 == 0) ifc.enable = ~ifc.enable;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
Drives a multiplexed 4x4 LED matrix so that the 16-step pattern is shown on the same grid as the button matrix. This is the output-side counterpart to button_matrix_controller: it selects one row at a time and drives the column lines from the stored beats. A step lights when its 4-bit pitch is non-zero. The playhead step (beat_count) blinks by inverting its lit state.

Parameters:
NUM_BEATS, 16, number of steps; fixed at 16 (4 rows x 4 columns).
ROW_TICKS, 3000, clocks per row slot, blank time included (250 us at 12 MHz).
BLANK_TICKS, 60, clocks at the start of each row slot with all lines off (anti-ghosting); constraint 1 <= BLANK_TICKS < ROW_TICKS.
BLINK_TICKS, 3_000_000, clocks per playhead blink half-period (250 ms at 12 MHz).

Ports:
clk  input  1  system clock, 12 MHz
rst_n  input  1  asynchronous active-low reset
enable  input  1  display enable; low blanks the display
beats  input  NUM_BEATS*4  step pitches; step s occupies bits [s*4+3 : s*4]
beat_count  input  4  current playhead step
row_outputs  output  4  row select, active-high, one-hot while driving
col_outputs  output  4  column sinks, active-low; bit c lights column c
frame_done  output  1  one-cycle pulse after row 3 slot completes

Behaviour:
- Step mapping: s = row*4 + col. lit(s) = (beats[s*4 +: 4] != 0).
- Shown value: lit(s) XOR (blink_phase AND s == beat_count).
- All outputs are registered.
- Reset (async, rst_n low):
  - row_outputs = 0000, col_outputs = 1111, frame_done = 0.
  - state = BLANK, row_idx = 0, slot counter = 0, blink counter = 0, blink_phase = 0.
  - Reset takes effect immediately, including mid-row.
- FSM states: BLANK, DRIVE.
  - BLANK: rows 0000, cols 1111.
    - Slot counter counts 0..BLANK_TICKS-1.
    - On the last count: latch the 4-bit shown vector for row_idx (using the current beats, beat_count and blink_phase), then go to DRIVE.
  - DRIVE: row_outputs = one-hot(row_idx), col_outputs = ~latched vector.
    - Counter runs through slot count ROW_TICKS-1.
    - On the last count: row_idx = (row_idx+1) mod 4, counter = 0, go to BLANK.
- Timing:
  - A slot entered at cycle t shows lines off for cycles t .. t+BLANK_TICKS-1.
  - Row is driven for cycles t+BLANK_TICKS .. t+ROW_TICKS-1.
  - Frame period is 4*ROW_TICKS.
- Snapshot rule: changes to beats or beat_count during DRIVE do not affect col_outputs until the next row latch. There is no tearing within a row.
- frame_done: asserted for exactly 1 cycle, in the first cycle of the row 0 BLANK slot that follows row 3 DRIVE. Not asserted for the first frame after reset or enable.
- Blink:
  - The free-running counter counts 0..BLINK_TICKS-1; at the wrap, blink_phase toggles.
  - It runs regardless of enable.
  - It is sampled only at row latch time.
- enable low:
  - On the next edge, force BLANK with row_idx = 0 and slot counter = 0; outputs off; no frame_done.
  - While held low, the block holds that state.
  - When enable rises, scanning restarts at row 0 BLANK. Row 0 is first driven BLANK_TICKS cycles later.
- Widths:
  - Slot counter is $clog2(ROW_TICKS) bits; blink counter is $clog2(BLINK_TICKS) bits.
  - Comparisons use parameter-1 constants; no overflow is possible.
- beat_count values: all 16 are valid; there is no out-of-range case.

Test Plan:
Bench parameters for all scenarios: ROW_TICKS = 8, BLANK_TICKS = 2, BLINK_TICKS = 20.
1. Reset mid-DRIVE of row 2
   -> same cycle: row = 0000, col = 1111, frame_done = 0.
   -> after rst_n rises: row = 0001 first appears 2 cycles later.
2. Pattern: beats with pitch 4'h3 at steps 0, 5, 10, 15 and zero elsewhere; beat_count = 8; blink_phase = 0
   -> row0 col = 1110, row1 col = 1101, row2 col = 1011, row3 col = 0111.
   -> each row is driven 6 cycles and blanked 2 cycles.
3. Playhead: beats = 0, beat_count = 6
   -> row1 col = 1111 while blink_phase = 0; row1 col = 1011 while blink_phase = 1.
   -> phase toggles every 20 cycles; rows 0, 2, 3 stay at 1111.
   -> Also: pitch 4'h1 at step 6 gives the inverse pattern.
4. Frame timing, enable held high
   -> frame_done is high for exactly 1 cycle every 32 cycles, coinciding with row 0 BLANK entry.
   -> No pulse in the first 32 cycles after reset.
5. Snapshot: change step 4 from 0 to 4'h7 three cycles into row1 DRIVE
   -> row1 col stays 1111 for the rest of that slot.
   -> next frame: row1 col = 1110.
6. Enable drop: enable low during row2 DRIVE
   -> next cycle: row = 0000, col = 1111, held there.
   -> after enable rises: row0 is driven after 2 cycles; frame_done fires only after a full 32-cycle frame.
